// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3): one adjust+shift per clock,
// start/ready/done handshake, result held in bcd_out until the next completion.
module bin_to_bcd_seq #(
    parameter int unsigned BIN_W  = 12,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int unsigned CW = $clog2(BIN_W + 1);
    localparam int unsigned SW = 4 * DIGITS;
    localparam int unsigned TW = SW + BIN_W;
    localparam logic [CW-1:0] CNT_INIT = CW'(BIN_W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t            state_q, state_d;
    logic [BIN_W-1:0]  bin_q,   bin_d;
    logic [SW-1:0]     scr_q,   scr_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [SW-1:0]     bcd_q,   bcd_d;
    logic              done_q,  done_d;

    logic [SW-1:0]     adj;
    logic [TW-1:0]     shifted;
    logic [3:0]        digit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    // Add-3 correction per digit, then one combined left shift of {scratch, binary}
    always_comb begin
        adj   = scr_q;
        digit = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            digit = scr_q[4*i +: 4];
            if (digit >= 4'd5) begin
                adj[4*i +: 4] = digit + 4'd3;
            end
        end
        shifted = {adj, bin_q} << 1;
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin_in;
                    scr_d   = '0;
                    cnt_d   = CNT_INIT;
                    state_d = CONV;
                end
            end
            CONV: begin
                scr_d = shifted[TW-1:BIN_W];
                bin_d = shifted[BIN_W-1:0];
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    bcd_d   = shifted[TW-1:BIN_W];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready   = (state_q == IDLE);
    assign done    = done_q;
    assign bcd_out = bcd_q;

endmodule
